// File: rtl/bridge_uart_arbiter.sv
// Two-requester round-robin bridge onto a single UART link: forwards one frame
// at a time and routes the read response (or a timeout) back to the owner.
module bridge_uart_arbiter #(
   parameter int FRAME_WIDTH    = 21,
   parameter int RESP_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [1:0]               req_valid,
   input  logic [2*FRAME_WIDTH-1:0] req_frame,
   output logic [1:0]               req_ready,
   output logic [1:0]               resp_valid,
   output logic [RESP_WIDTH-1:0]    resp_data,
   output logic                     resp_err,
   output logic [FRAME_WIDTH-1:0]   u_din,
   output logic                     u_en,
   input  logic                     u_tx_busy,
   input  logic                     u_rx_ready,
   input  logic [RESP_WIDTH-1:0]    u_dout,
   output logic [7:0]               drop_cnt
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      DRAIN     = 2'd2,
      WAIT_RESP = 2'd3
   } state_t;

   state_t                  state_r;
   logic                    prio_r;
   logic                    owner_r;
   logic                    is_read_r;
   logic                    rx_prev_r;
   logic [CNT_W-1:0]        tmo_cnt_r;
   logic [1:0]              req_ready_r;
   logic [1:0]              resp_valid_r;
   logic [RESP_WIDTH-1:0]   resp_data_r;
   logic                    resp_err_r;
   logic [FRAME_WIDTH-1:0]  u_din_r;
   logic                    u_en_r;
   logic [7:0]              drop_cnt_r;

   logic                    rx_evt_s;
   logic                    gnt_s;
   logic [FRAME_WIDTH-1:0]  gnt_frame_s;
   logic [1:0]              owner_oh_s;

   // prio selects the winner only when both requesters are asking
   function automatic logic rr_pick(input logic [1:0] valid, input logic prio);
      logic pick;
      case (valid)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         2'b11:   pick = prio;
         default: pick = 1'b0;
      endcase
      return pick;
   endfunction

   // RX edge detect, grant selection and owner decode
   always_comb begin
      rx_evt_s    = u_rx_ready & ~rx_prev_r;
      gnt_s       = rr_pick(req_valid, prio_r);
      if (gnt_s) begin
         gnt_frame_s = req_frame[FRAME_WIDTH +: FRAME_WIDTH];
      end else begin
         gnt_frame_s = req_frame[0 +: FRAME_WIDTH];
      end
      if (owner_r) begin
         owner_oh_s = 2'b10;
      end else begin
         owner_oh_s = 2'b01;
      end
   end

   // Transaction FSM with registered outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r      <= IDLE;
         prio_r       <= 1'b0;
         owner_r      <= 1'b0;
         is_read_r    <= 1'b0;
         rx_prev_r    <= 1'b0;
         tmo_cnt_r    <= '0;
         req_ready_r  <= 2'b00;
         resp_valid_r <= 2'b00;
         resp_data_r  <= '0;
         resp_err_r   <= 1'b0;
         u_din_r      <= '0;
         u_en_r       <= 1'b0;
         drop_cnt_r   <= 8'd0;
      end else begin
         rx_prev_r    <= u_rx_ready;
         req_ready_r  <= 2'b00;
         resp_valid_r <= 2'b00;

         // outside WAIT_RESP nobody is expecting data
         if (rx_evt_s && (state_r != WAIT_RESP) && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
         end

         case (state_r)
            IDLE: begin
               if (|req_valid) begin
                  req_ready_r <= gnt_s ? 2'b10 : 2'b01;
                  u_din_r     <= gnt_frame_s;
                  owner_r     <= gnt_s;
                  is_read_r   <= ~gnt_frame_s[FRAME_WIDTH-1];
                  prio_r      <= ~gnt_s;
                  u_en_r      <= 1'b1;
                  state_r     <= SEND;
               end
            end
            SEND: begin
               if (u_tx_busy) begin
                  u_en_r  <= 1'b0;
                  state_r <= DRAIN;
               end
            end
            DRAIN: begin
               if (!u_tx_busy) begin
                  if (is_read_r) begin
                     tmo_cnt_r <= '0;
                     state_r   <= WAIT_RESP;
                  end else begin
                     state_r   <= IDLE;
                  end
               end
            end
            WAIT_RESP: begin
               // a response arriving on the expiry cycle still wins
               if (rx_evt_s) begin
                  resp_valid_r <= owner_oh_s;
                  resp_data_r  <= u_dout;
                  resp_err_r   <= 1'b0;
                  state_r      <= IDLE;
               end else if (tmo_cnt_r == CNT_LAST) begin
                  resp_valid_r <= owner_oh_s;
                  resp_data_r  <= '0;
                  resp_err_r   <= 1'b1;
                  state_r      <= IDLE;
               end else begin
                  tmo_cnt_r    <= tmo_cnt_r + CNT_W'(1);
               end
            end
            default: begin
               u_en_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_data  = resp_data_r;
   assign resp_err   = resp_err_r;
   assign u_din      = u_din_r;
   assign u_en       = u_en_r;
   assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_bridge_uart_arbiter.sv
// Directed bench for bridge_uart_arbiter: writes, contention, reads, timeout,
// drop counter saturation and reset during an outstanding read.
module tb_bridge_uart_arbiter;

   localparam int FW = 21;
   localparam int RW = 8;

   logic            clk = 1'b0;
   logic            rstn;
   logic [1:0]      req_valid;
   logic [2*FW-1:0] req_frame;
   logic [1:0]      req_ready;
   logic [1:0]      resp_valid;
   logic [RW-1:0]   resp_data;
   logic            resp_err;
   logic [FW-1:0]   u_din;
   logic            u_en;
   logic            u_tx_busy;
   logic            u_rx_ready;
   logic [RW-1:0]   u_dout;
   logic [7:0]      drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   bridge_uart_arbiter #(
      .FRAME_WIDTH(FW),
      .RESP_WIDTH(RW),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_frame(req_frame),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_err(resp_err), .u_din(u_din), .u_en(u_en), .u_tx_busy(u_tx_busy),
      .u_rx_ready(u_rx_ready), .u_dout(u_dout), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_reset();
      rstn       = 1'b0;
      req_valid  = 2'b00;
      u_tx_busy  = 1'b0;
      u_rx_ready = 1'b0;
      u_dout     = 8'h00;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_req_ready"},  32'(req_ready),  32'h0);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
      chk({tag, "_resp_data"},  32'(resp_data),  32'h0);
      chk({tag, "_resp_err"},   32'(resp_err),   32'h0);
      chk({tag, "_u_din"},      32'(u_din),      32'h0);
      chk({tag, "_u_en"},       32'(u_en),       32'h0);
      chk({tag, "_drop_cnt"},   32'(drop_cnt),   32'h0);
   endtask

   task automatic wait_grant(input string tag, output logic [1:0] g);
      g = 2'b00;
      for (int i = 0; i < 20 && g == 2'b00; i++) begin
         tick();
         g = req_ready;
      end
      chk({tag, "_grant_seen"}, 32'(g != 2'b00), 32'h1);
   endtask

   // Busy rises (SEND -> DRAIN), is held, then falls (DRAIN exits)
   task automatic send_phase(input string tag);
      u_tx_busy = 1'b1;
      tick();
      chk({tag, "_u_en_drain"}, 32'(u_en), 32'h0);
      tick();
      u_tx_busy = 1'b0;
      tick();
   endtask

   task automatic rx_pulse();
      u_rx_ready = 1'b1;
      tick();
      u_rx_ready = 1'b0;
      tick();
   endtask

   task automatic count_resp(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (resp_valid != 2'b00) pulses++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0]  g;
      logic [1:0]  rv;
      logic [7:0]  rd;
      logic        re;
      int          pulses;
      int          first;
      logic [FW-1:0] f0;
      logic [FW-1:0] f1;

      req_frame = '0;
      apply_reset();
      chk_zero_outputs("rst");

      // single write from requester 0
      req_frame[FW-1:0] = 21'h1A5123;
      req_valid = 2'b01;
      wait_grant("wr", g);
      req_valid = 2'b00;
      chk("wr_grant", 32'(g), 32'h1);
      chk("wr_u_din", 32'(u_din), 32'h1A5123);
      chk("wr_u_en", 32'(u_en), 32'h1);
      tick();
      chk("wr_ready_pulse", 32'(req_ready), 32'h0);
      chk("wr_u_en_hold", 32'(u_en), 32'h1);
      send_phase("wr");
      count_resp(6, pulses);
      chk("wr_no_resp", 32'(pulses), 32'h0);
      chk("wr_u_din_stable", 32'(u_din), 32'h1A5123);
      chk("wr_u_en_idle", 32'(u_en), 32'h0);

      // contention with both requests held
      apply_reset();
      f0 = 21'h111001;
      f1 = 21'h122002;
      req_frame = {f1, f0};
      req_valid = 2'b11;
      for (int t = 0; t < 4; t++) begin
         wait_grant("rr", g);
         chk($sformatf("rr%0d_grant", t), 32'(g), (t % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("rr%0d_u_din", t), 32'(u_din), (t % 2 == 0) ? 32'(f0) : 32'(f1));
         tick();
         chk($sformatf("rr%0d_ready_pulse", t), 32'(req_ready), 32'h0);
         send_phase("rr");
      end
      req_valid = 2'b00;

      // read from requester 1
      req_frame[2*FW-1:FW] = 21'h000045;
      req_valid = 2'b10;
      wait_grant("rd", g);
      req_valid = 2'b00;
      chk("rd_grant", 32'(g), 32'h2);
      send_phase("rd");
      u_dout = 8'h3C;
      u_rx_ready = 1'b1;
      tick();
      chk("rd_resp_valid", 32'(resp_valid), 32'h2);
      chk("rd_resp_data", 32'(resp_data), 32'h3C);
      chk("rd_resp_err", 32'(resp_err), 32'h0);
      u_rx_ready = 1'b0;
      tick();
      chk("rd_resp_pulse", 32'(resp_valid), 32'h0);
      chk("rd_drop_cnt", 32'(drop_cnt), 32'h0);

      // rx_ready held high for 10 cycles in WAIT_RESP
      req_frame[FW-1:0] = 21'h000050;
      req_valid = 2'b01;
      wait_grant("hold", g);
      req_valid = 2'b00;
      send_phase("hold");
      u_dout = 8'h5A;
      u_rx_ready = 1'b1;
      count_resp(10, pulses);
      u_rx_ready = 1'b0;
      tick();
      chk("hold_one_resp", 32'(pulses), 32'h1);
      chk("hold_resp_data", 32'(resp_data), 32'h5A);
      chk("hold_drop_cnt", 32'(drop_cnt), 32'h0);

      // read timeout from requester 0, then a late response
      req_frame[FW-1:0] = 21'h000777;
      req_valid = 2'b01;
      wait_grant("tmo", g);
      req_valid = 2'b00;
      send_phase("tmo");
      first = 0;
      rv = 2'b00; rd = 8'h00; re = 1'b0;
      for (int k = 1; k <= 40 && first == 0; k++) begin
         tick();
         if (resp_valid != 2'b00) begin
            first = k;
            rv = resp_valid;
            rd = resp_data;
            re = resp_err;
         end
      end
      chk("tmo_latency", 32'(first), 32'd16);
      chk("tmo_resp_valid", 32'(rv), 32'h1);
      chk("tmo_resp_err", 32'(re), 32'h1);
      chk("tmo_resp_data", 32'(rd), 32'h0);
      tick();
      chk("tmo_resp_pulse", 32'(resp_valid), 32'h0);
      rx_pulse();
      chk("tmo_late_drop", 32'(drop_cnt), 32'h1);

      // drop counter saturation
      apply_reset();
      repeat (254) rx_pulse();
      chk("sat_254", 32'(drop_cnt), 32'd254);
      rx_pulse();
      chk("sat_255", 32'(drop_cnt), 32'd255);
      rx_pulse();
      chk("sat_hold", 32'(drop_cnt), 32'd255);

      // reset during WAIT_RESP, then a fresh contended request
      apply_reset();
      req_frame[FW-1:0] = 21'h000ABC;
      req_valid = 2'b01;
      wait_grant("mid", g);
      req_valid = 2'b00;
      send_phase("mid");
      repeat (3) tick();
      rstn = 1'b0;
      tick();
      chk_zero_outputs("midrst");
      rstn = 1'b1;
      count_resp(25, pulses);
      chk("midrst_no_resp", 32'(pulses), 32'h0);
      req_frame = {21'h1C3D21, 21'h1FF0F0};
      req_valid = 2'b11;
      wait_grant("post", g);
      req_valid = 2'b00;
      chk("post_grant", 32'(g), 32'h1);
      chk("post_u_din", 32'(u_din), 32'h1FF0F0);
      chk("post_u_en", 32'(u_en), 32'h1);
      send_phase("post");
      count_resp(5, pulses);
      chk("post_no_resp", 32'(pulses), 32'h0);
      chk("post_u_en_idle", 32'(u_en), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
